// File: rtl/narrow_serializer.sv
// ---------------------------------------------------------------------------
// narrow_serializer
//
// Purpose:
//   Takes one 64-bit word and streams it out as WIDTH-bit chunks, least
//   significant chunk first. This is the reverse of the datapath zero
//   extenders: it narrows a 64-bit register value onto a narrow bus, such as
//   a byte-wide debug or UART port. When fewer than all chunks are requested,
//   out_trunc flags that the unsent upper bits were nonzero. In that case,
//   zero-extending the sent chunks would not rebuild the original word.
//
// Parameters:
//   WIDTH      chunk width in bits. Legal values: 1, 2, 4, 8, 16, 32, 64.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   upstream offers a word
//   in_ready   block can accept a word (registered)
//   in_data    64-bit word to serialize
//   in_count   chunks to send; 0 or anything above NCHUNK means NCHUNK
//   out_valid  out_data holds a valid chunk
//   out_ready  downstream accepts the current chunk
//   out_data   current chunk
//   out_last   current chunk is the final one of the word
//   out_trunc  discarded upper bits were nonzero (valid with out_valid)
// ---------------------------------------------------------------------------
module narrow_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic [6:0]       in_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_trunc
);

    localparam int         NCHUNK  = 64 / WIDTH;
    localparam logic [6:0] NCHUNK7 = 7'(NCHUNK);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t      state;
    logic [63:0] sh;
    logic [6:0]  rem;
    logic        trunc;

    logic [6:0]  eff_count;
    logic        trunc_next;

    // A zero count or an oversized count both mean "send the whole word".
    always_comb begin
        eff_count = in_count;
        if (in_count == 7'd0 || in_count > NCHUNK7) begin
            eff_count = NCHUNK7;
        end
    end

    // OR together every chunk at or above the effective count. Working chunk
    // by chunk avoids any shift-by-64 mask arithmetic, and a full-width count
    // naturally selects no chunks at all.
    always_comb begin
        trunc_next = 1'b0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (7'(i) >= eff_count) begin
                trunc_next = trunc_next | (|in_data[i*WIDTH +: WIDTH]);
            end
        end
    end

    // The control FSM and datapath registers.
    // In IDLE, in_ready is forced high on every edge without a handshake.
    // This makes it rise on the first edge after reset release. It also
    // keeps it high while the block waits for a word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sh       <= '0;
            rem      <= '0;
            trunc    <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sh       <= in_data;
                        rem      <= eff_count;
                        trunc    <= trunc_next;
                        in_ready <= 1'b0;
                        state    <= SEND;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        sh  <= sh >> WIDTH;
                        rem <= rem - 7'd1;
                        if (rem == 7'd1) begin
                            state    <= IDLE;
                            in_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs are pure decode of registers. They are forced to zero outside
    // SEND, so leftover shift-register contents never leak onto the bus.
    always_comb begin
        out_valid = (state == SEND);
        out_data  = '0;
        out_last  = 1'b0;
        out_trunc = 1'b0;
        if (state == SEND) begin
            out_data  = sh[WIDTH-1:0];
            out_last  = (rem == 7'd1);
            out_trunc = trunc;
        end
    end

endmodule

// File: doc/narrow_serializer.md
# narrow_serializer

- Accepts one 64-bit word and emits it as a stream of WIDTH-bit chunks, least-significant chunk first.
- Works in the opposite direction to the datapath's zero extenders: it narrows a 64-bit register value onto a narrow bus, such as a byte-wide debug or UART port.
- Reports whether the unsent upper bits were nonzero, meaning zero-extending the sent chunks would not rebuild the original word.
- Both sides use valid/ready handshakes; one word is in flight at a time.

## Interface
Parameters:
- WIDTH, 8, chunk width in bits; legal values are 1, 2, 4, 8, 16, 32, 64 (must divide 64). Derived NCHUNK = 64/WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  word offered.
- in_ready  output  1  block can accept a word.
- in_data  input  64  word to serialize.
- in_count  input  7  number of chunks to send. 0 or any value > NCHUNK means NCHUNK.
- out_valid  output  1  out_data holds a valid chunk.
- out_ready  input  1  downstream accepts the chunk.
- out_data  output  WIDTH  current chunk.
- out_last  output  1  current chunk is the final one of the word.
- out_trunc  output  1  discarded upper bits were nonzero; meaningful only while out_valid is high.

## Operation
- State registers:
  - FSM state: IDLE or SEND.
  - 64-bit shift register `sh`.
  - 7-bit counter `rem`.
  - 1-bit `trunc`.
  - Registered `in_ready`.
- Reset asserted (asynchronous):
  - State goes to IDLE; sh = 0; rem = 0; trunc = 0; in_ready = 0.
  - Outputs: out_valid = 0, out_last = 0, out_trunc = 0, out_data = 0.
- First rising edge after reset deasserts: in_ready goes to 1.
- IDLE, with in_valid && in_ready at an edge:
  - Load sh = in_data.
  - Load rem = effective count C (1..NCHUNK).
  - Load trunc = OR of in_data[63 : C*WIDTH]; this is 0 when C = NCHUNK.
  - in_ready goes to 0; state goes to SEND.
- IDLE without a handshake: nothing changes.
- SEND outputs:
  - out_valid = 1.
  - out_data = sh[WIDTH-1:0].
  - out_last = (rem == 1).
  - out_trunc = trunc.
- SEND, with out_ready high at an edge:
  - sh shifts right by WIDTH with zero fill; rem decrements.
  - If it was the last chunk: state goes to IDLE and in_ready goes to 1.
- SEND, with out_ready low: out_data, out_last, out_trunc and rem hold stable.
- in_valid and in_data are ignored outside IDLE. A word presented during SEND is not captured.
- Arithmetic: C*WIDTH is at most 64. The mask for the trunc computation is built from the effective count only; no wrap occurs.

## Timing
- Latency: a word accepted at edge N gives out_valid = 1 from edge N (first chunk visible in the cycle after N).
- With out_ready held high, a count-C word occupies C consecutive cycles of out_valid.
- in_ready rises at the same edge as the last output handshake. The next word can be accepted one edge later.
- Sustained throughput is one word per C+1 cycles.
- All outputs are driven from registers or from decode of registers only; there is no combinational path from any input to any output.
- Reset asserted mid-SEND:
  - Outputs drop immediately (asynchronously).
  - The partially sent word is discarded.
  - After release, no residual chunks appear.

## Test plan
- Basic two-chunk word: WIDTH=8, in_data=64'h0000_0000_0000_ABCD, in_count=2, out_ready=1.
  - Beats are 8'hCD then 8'hAB.
  - out_last is high on beat 2 only; out_trunc = 0.
  - in_ready returns high at the same edge as the last handshake.
- Truncated word: same data, in_count=1.
  - Single beat 8'hCD with out_last=1 and out_trunc=1.
- Full-width default: in_count=0, in_data=64'h0123_4567_89AB_CDEF.
  - 8 beats: EF, CD, AB, 89, 67, 45, 23, 01.
  - out_last on beat 8; out_trunc=0.
- Backpressure: in_count=3, out_ready pattern 0,1,0,0,1,1.
  - out_data stays stable while out_valid && !out_ready.
  - Exactly 3 handshakes occur, in order, with no duplicates or skips.
- Ignored input during SEND: during SEND, drive in_valid=1 with a different in_data.
  - No capture; in_ready stays 0; the original chunks are unaffected.
- Reset mid-word: assert reset after beat 1 of a 4-beat word.
  - out_valid = 0 and in_ready = 0 immediately.
  - After release, in_ready goes to 1 at the next edge and no stale beats are emitted.
